// File: rtl/crc.sv
// -----------------------------------------------------------------------------
// crc -- serial CRC generator built on a Galois-style LFSR.
//
// Message bits enter LSB-first on DATA while ACTIVE is high. On the first cycle
// ACTIVE is low, the finished CRC is shifted out LSB-first on cRc. Valid is
// high for exactly WIDTH cycles while cRc carries CRC bits. The block then
// reloads SEED and returns to IDLE.
//
// Ports
//   CLK     in   1  clock, rising edge
//   RST     in   1  synchronous active-high reset
//   ACTIVE  in   1  DATA carries a message bit this cycle
//   DATA    in   1  serial message bit, LSB-first
//   cRc     out  1  serial CRC bit, LSB-first, registered
//   Valid   out  1  cRc carries a CRC bit, registered
//
// Handshake: there is no back-pressure. ACTIVE acts as a valid qualifier on
// DATA and is sampled only in IDLE/CALC. Valid qualifies cRc, and the consumer
// must take each bit in the cycle it is presented.
// -----------------------------------------------------------------------------
module crc #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 8'hD8,
  parameter logic [WIDTH-1:0] TAPS  = 8'b0100_0100
) (
  input  logic CLK,
  input  logic RST,
  input  logic ACTIVE,
  input  logic DATA,
  output logic cRc,
  output logic Valid
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Internal state, visible by name for checkers.
  state_t           state, state_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             crc_nxt, valid_nxt;

  logic             fb;
  logic [WIDTH-1:0] lfsr_step;

  // Feedback goes into the top stage. Tapped stages below it also XOR in the
  // feedback bit as the register shifts down toward bit 0.
  assign fb        = DATA ^ lfsr[0];
  assign lfsr_step = {fb, lfsr[WIDTH-1:1] ^ (TAPS[WIDTH-2:0] & {(WIDTH-1){fb}})};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      lfsr  <= SEED;
      count <= '0;
      cRc   <= 1'b0;
      Valid <= 1'b0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      count <= count_nxt;
      cRc   <= crc_nxt;
      Valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    count_nxt = count;
    crc_nxt   = 1'b0;
    valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (ACTIVE) begin
          lfsr_nxt  = lfsr_step;
          state_nxt = CALC;
        end
      end

      CALC: begin
        if (ACTIVE) begin
          lfsr_nxt = lfsr_step;
        end else begin
          // The first low cycle already presents CRC bit 0, and DATA is
          // ignored in this cycle.
          crc_nxt   = lfsr[0];
          lfsr_nxt  = lfsr >> 1;
          valid_nxt = 1'b1;
          count_nxt = CW'(1);
          state_nxt = OUT;
        end
      end

      OUT: begin
        if (count == CW'(WIDTH)) begin
          lfsr_nxt  = SEED;
          count_nxt = '0;
          state_nxt = IDLE;
        end else begin
          crc_nxt   = lfsr[0];
          lfsr_nxt  = lfsr >> 1;
          valid_nxt = 1'b1;
          count_nxt = count + CW'(1);
        end
      end

      default: begin
        lfsr_nxt  = SEED;
        count_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_crc.sv
// -----------------------------------------------------------------------------
// tb_crc -- self-checking bench for the serial CRC generator.
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge. Expected CRC bits come from an arithmetic model of the
// polynomial division and are queued in exp_q.
// -----------------------------------------------------------------------------
module tb_crc;

  localparam int         WIDTH = 8;
  localparam logic [7:0] SEED  = 8'hD8;
  localparam logic [7:0] TAPS  = 8'b0100_0100;

  logic CLK;
  logic RST;
  logic ACTIVE;
  logic DATA;
  logic cRc;
  logic Valid;

  logic [0:0] exp_q[$];
  int n_cmp;
  int n_bad;

  crc #(.WIDTH(WIDTH), .SEED(SEED), .TAPS(TAPS)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .ACTIVE (ACTIVE),
    .DATA   (DATA),
    .cRc    (cRc),
    .Valid  (Valid)
  );

  // Clock and reset.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. Each message bit divides the running remainder by the
  // polynomial. The reflected form is x^8 plus the tap positions.
  function automatic logic [7:0] model_crc(input int len, input logic [63:0] bits);
    int unsigned rem;
    int unsigned poly;
    rem  = SEED;
    poly = 32'h80 | TAPS;
    for (int i = 0; i < len; i++) begin
      if (((rem ^ bits[i]) & 1) != 0) rem = (rem / 2) ^ poly;
      else                            rem = rem / 2;
    end
    return rem[7:0];
  endfunction

  // Idle cycles. No output activity is allowed.
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check_eq("idle_valid", Valid, 0);
      check_eq("idle_crc",   cRc,   0);
      ACTIVE = 1'b0;
      DATA   = 1'($urandom_range(0, 1));
    end
  endtask

  // Send one message and check the serial CRC that follows. If disturb is
  // set, ACTIVE/DATA are randomised while the CRC is being shifted out.
  task automatic send_msg(input int len, input logic [63:0] bits, input bit disturb);
    logic [7:0] c;
    c = model_crc(len, bits);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(c[i]);
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      ACTIVE = 1'b1;
      DATA   = bits[i];
    end
    @(negedge CLK);
    ACTIVE = 1'b0;
    DATA   = 1'($urandom_range(0, 1));
    for (int k = 0; k <= WIDTH; k++) begin
      @(negedge CLK);
      if (k < WIDTH) begin
        check_eq("out_valid", Valid, 1);
        if (exp_q.size() > 0) check_eq("out_bit", cRc, exp_q.pop_front());
        else                  check_eq("out_q_empty", 1, 0);
        if (disturb) begin
          ACTIVE = 1'($urandom_range(0, 1));
          DATA   = 1'($urandom_range(0, 1));
        end
      end else begin
        check_eq("end_valid", Valid, 0);
        check_eq("end_crc",   cRc,   0);
        check_eq("end_q",     exp_q.size(), 0);
        ACTIVE = 1'b0;
        DATA   = 1'b0;
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    RST    = 1'b1;
    ACTIVE = 1'b0;
    DATA   = 1'b0;

    // Hold reset for two cycles.
    repeat (2) @(negedge CLK);
    check_eq("rst_valid", Valid, 0);
    check_eq("rst_crc",   cRc,   0);
    RST = 1'b0;

    // No activity after reset.
    idle_check(20);

    // Known vector: an all-zero byte gives 8'h14.
    check_eq("model_zero", model_crc(8, 64'h0), 8'h14);
    send_msg(8, 64'h0, 1'b0);

    // Send the vector back-to-back with one idle cycle between messages.
    idle_check(1);
    send_msg(8, 64'h0, 1'b0);

    // Reset after 4 message bits, then send a clean message.
    idle_check(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      ACTIVE = 1'b1;
      DATA   = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    RST    = 1'b1;
    ACTIVE = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    check_eq("midrst_valid", Valid, 0);
    idle_check(3);
    send_msg(8, 64'h0, 1'b0);

    // Disturb ACTIVE/DATA while the CRC is shifted out.
    idle_check(1);
    send_msg(8, 64'h0, 1'b1);

    // Minimal single-bit messages.
    idle_check(1);
    send_msg(1, 64'h1, 1'b0);
    send_msg(1, 64'h0, 1'b1);

    // Randomised messages and gaps. A gap of 0 starts right after return to IDLE.
    for (int m = 0; m < 40; m++) begin
      send_msg($urandom_range(1, 64), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      idle_check($urandom_range(0, 3));
    end

    idle_check(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
